layered_frame_compositor: RTL and testbench

//  Parametrised N-layer pixel compositor between the per-layer renderers (game area, stats, ...) and the video output pins.

---
 rtl/layered_frame_compositor_if.sv | 50 +++++
 rtl/layered_frame_compositor.sv | 192 +++++++++++++++++++
 tb/tb_layered_frame_compositor.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/layered_frame_compositor_if.sv
`default_nettype none
// ============================================================================
// Module   : layered_frame_compositor_if
// Purpose  : Groups the pixel-timing, layer and frame-handshake signals that
//            connect the timing generator, layer renderers and game logic to
//            the layered frame compositor.
// Ports    : master - drives timing/layer/ack inputs, receives video + status
//            slave  - compositor side (consumes inputs, drives outputs)
// Revision : 1.0 - initial release
// ============================================================================
interface layered_frame_compositor_if #(
  parameter int NUM_LAYERS  = 3,
  parameter int COLOR_W     = 8,
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int FRAME_CNT_W = 16
);
  // Timing generator side
  logic [X_W-1:0]                x_pixel;
  logic [Y_W-1:0]                y_pixel;
  logic                          hsync_in;
  logic                          vsync_in;
  // Layer renderers
  logic [NUM_LAYERS*COLOR_W-1:0] layer_color;
  logic [NUM_LAYERS-1:0]         layer_opaque;
  logic [COLOR_W-1:0]            bg_color;
  logic                          mode;
  // Game logic handshake
  logic                          frame_ack;
  // Video output and status
  logic [COLOR_W-1:0]            color;
  logic                          hsync;
  logic                          vsync;
  logic                          frame_done;
  logic [FRAME_CNT_W-1:0]        frame_count;
  logic [7:0]                    overrun_count;

  modport master (
    output x_pixel, y_pixel, hsync_in, vsync_in,
    output layer_color, layer_opaque, bg_color, mode, frame_ack,
    input  color, hsync, vsync, frame_done, frame_count, overrun_count
  );

  modport slave (
    input  x_pixel, y_pixel, hsync_in, vsync_in,
    input  layer_color, layer_opaque, bg_color, mode, frame_ack,
    output color, hsync, vsync, frame_done, frame_count, overrun_count
  );
endinterface
`default_nettype wire

// File: rtl/layered_frame_compositor.sv
`default_nettype none
// ============================================================================
// Module   : layered_frame_compositor
// Purpose  : N-layer pixel compositor. Merges per-layer colour/opacity
//            (priority mux or OR-blend), blanks outside the active area and
//            delays HSYNC/VSYNC through a fixed PIPE_STAGES-deep pipeline so
//            they stay pixel-aligned. Also raises a frame-done handshake
//            toward game logic and counts frames.
// Ports    : clk      - pixel clock
//            reset_n  - asynchronous active-low reset
//            bus      - layered_frame_compositor_if.slave (timing, layers,
//                       mode, frame_ack in; color, syncs, frame_done,
//                       frame_count, overrun_count out)
// Config   : COMPOSITOR_OVERRUN_CNT_EN - when defined, overrun_count counts
//            unacknowledged frame events (saturating at 255); otherwise it
//            is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module layered_frame_compositor #(
  parameter int NUM_LAYERS  = 3,
  parameter int COLOR_W     = 8,
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 600,
  parameter int FRAME_LINE  = 600,
  parameter int PIPE_STAGES = 2,
  parameter int FRAME_CNT_W = 16,
  parameter bit SYNC_IDLE   = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  layered_frame_compositor_if.slave bus
);

  localparam logic [X_W-1:0] c_h_active   = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] c_v_active   = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] c_frame_line = Y_W'(FRAME_LINE);

  // --------------------------------------------------------------------------
  // Composite: evaluated on the raw inputs so that mode, background and all
  // layers are taken from the same pixel, then captured at stage 1.
  // --------------------------------------------------------------------------
  logic [COLOR_W-1:0] w_prio;
  logic [COLOR_W-1:0] w_or;
  logic               w_any;
  logic               w_blank;
  logic [COLOR_W-1:0] w_pix;

  always_comb begin
    w_prio  = bus.bg_color;
    w_or    = '0;
    w_any   = 1'b0;
    w_blank = (bus.x_pixel >= c_h_active) || (bus.y_pixel >= c_v_active);
    // Walk from the highest index down so the lowest opaque layer wins.
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (bus.layer_opaque[i]) begin
        w_prio = bus.layer_color[i*COLOR_W +: COLOR_W];
        w_or   = w_or | bus.layer_color[i*COLOR_W +: COLOR_W];
        w_any  = 1'b1;
      end
    end
    if (w_blank) begin
      w_pix = '0;
    end else if (!w_any) begin
      w_pix = bus.bg_color;
    end else if (bus.mode) begin
      w_pix = w_or;
    end else begin
      w_pix = w_prio;
    end
  end

  // --------------------------------------------------------------------------
  // Pixel / sync delay line. Colour and syncs share one pipeline so they can
  // never drift apart.
  // --------------------------------------------------------------------------
  logic [COLOR_W-1:0]     r_color_pipe [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] r_hs_pipe;
  logic [PIPE_STAGES-1:0] r_vs_pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        r_color_pipe[s] <= '0;
      end
      r_hs_pipe <= {PIPE_STAGES{SYNC_IDLE}};
      r_vs_pipe <= {PIPE_STAGES{SYNC_IDLE}};
    end else begin
      r_color_pipe[0] <= w_pix;
      r_hs_pipe[0]    <= bus.hsync_in;
      r_vs_pipe[0]    <= bus.vsync_in;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        r_color_pipe[s] <= r_color_pipe[s-1];
        r_hs_pipe[s]    <= r_hs_pipe[s-1];
        r_vs_pipe[s]    <= r_vs_pipe[s-1];
      end
    end
  end

  assign bus.color = r_color_pipe[PIPE_STAGES-1];
  assign bus.hsync = r_hs_pipe[PIPE_STAGES-1];
  assign bus.vsync = r_vs_pipe[PIPE_STAGES-1];

  // --------------------------------------------------------------------------
  // Frame event: rising edge of (x==0 && y==FRAME_LINE). The previous value
  // of the condition is held so a stalled X at 0 fires only once.
  // --------------------------------------------------------------------------
  logic w_frame_cond;
  logic r_frame_cond;
  logic w_frame_evt;

  assign w_frame_cond = (bus.x_pixel == '0) && (bus.y_pixel == c_frame_line);
  assign w_frame_evt  = w_frame_cond & ~r_frame_cond;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cond <= 1'b0;
    end else begin
      r_frame_cond <= w_frame_cond;
    end
  end

  // --------------------------------------------------------------------------
  // Frame-done handshake
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [FRAME_CNT_W-1:0] r_frame_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_frame_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_frame_evt) begin
        r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_frame_evt) begin
          w_state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        // A new event re-arms even when an ack arrives in the same cycle.
        if (!w_frame_evt && bus.frame_ack) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign bus.frame_done  = (r_state == ST_PEND);
  assign bus.frame_count = r_frame_count;

  // --------------------------------------------------------------------------
  // Overrun counter
  // --------------------------------------------------------------------------
`ifdef COMPOSITOR_OVERRUN_CNT_EN
  logic       w_overrun;
  logic [7:0] r_overrun_cnt;

  assign w_overrun = (r_state == ST_PEND) && w_frame_evt && !bus.frame_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun_cnt <= 8'd0;
    end else if (w_overrun && (r_overrun_cnt != 8'hFF)) begin
      r_overrun_cnt <= r_overrun_cnt + 8'd1;
    end
  end

  assign bus.overrun_count = r_overrun_cnt;
`else
  assign bus.overrun_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_layered_frame_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tb_layered_frame_compositor
// Purpose  : Self-checking bench for layered_frame_compositor: table of pixel
//            vectors plus directed sync, handshake, overrun and reset
//            sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layered_frame_compositor;

  localparam int NL  = 3;
  localparam int CW  = 8;
  localparam int XW  = 11;
  localparam int YW  = 10;
  localparam int FCW = 16;

`ifdef COMPOSITOR_OVERRUN_CNT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  layered_frame_compositor_if #(
    .NUM_LAYERS(NL), .COLOR_W(CW), .X_W(XW), .Y_W(YW), .FRAME_CNT_W(FCW)
  ) bus ();

  layered_frame_compositor #(
    .NUM_LAYERS(NL), .COLOR_W(CW), .X_W(XW), .Y_W(YW),
    .H_ACTIVE(800), .V_ACTIVE(600), .FRAME_LINE(600), .PIPE_STAGES(2),
    .FRAME_CNT_W(FCW), .SYNC_IDLE(1'b1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          mode;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [NL-1:0] opq;
    logic [23:0]   lc;
    logic [7:0]    bg;
    logic [7:0]    exp;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic frame_evt();
    bus.y_pixel = 10'd600;
    tick();
    bus.y_pixel = 10'd601;
    tick();
  endtask

  logic [7:0] prev_exp;
  logic [7:0] hpat;
  logic [7:0] vpat;

  initial begin
    checks = 0;
    errors = 0;
    // Layer colours packed {L2, L1, L0}
    vecs[0]  = '{1'b0, 11'd10,   10'd10,   3'b110, 24'hE01C55, 8'h03, 8'h1C};
    vecs[1]  = '{1'b1, 11'd10,   10'd10,   3'b110, 24'hE01C55, 8'h03, 8'hFC};
    vecs[2]  = '{1'b1, 11'd10,   10'd10,   3'b000, 24'hE01C55, 8'h03, 8'h03};
    vecs[3]  = '{1'b0, 11'd10,   10'd10,   3'b000, 24'hE01C55, 8'h03, 8'h03};
    vecs[4]  = '{1'b0, 11'd10,   10'd10,   3'b111, 24'hE01C55, 8'h03, 8'h55};
    vecs[5]  = '{1'b1, 11'd10,   10'd10,   3'b101, 24'hE01C55, 8'h03, 8'hF5};
    vecs[6]  = '{1'b0, 11'd800,  10'd10,   3'b001, 24'hE01CFF, 8'h03, 8'h00};
    vecs[7]  = '{1'b0, 11'd799,  10'd599,  3'b001, 24'hE01CFF, 8'h03, 8'hFF};
    vecs[8]  = '{1'b0, 11'd10,   10'd600,  3'b001, 24'hE01CFF, 8'h03, 8'h00};
    vecs[9]  = '{1'b1, 11'd0,    10'd0,    3'b100, 24'hE01CFF, 8'h03, 8'hE0};
    vecs[10] = '{1'b0, 11'd2047, 10'd1023, 3'b000, 24'hE01CFF, 8'h03, 8'h00};

    // Idle inputs
    reset_n          = 1'b1;
    bus.x_pixel      = '0;
    bus.y_pixel      = '0;
    bus.hsync_in     = 1'b1;
    bus.vsync_in     = 1'b1;
    bus.layer_color  = '0;
    bus.layer_opaque = '0;
    bus.bg_color     = '0;
    bus.mode         = 1'b0;
    bus.frame_ack    = 1'b0;

    #1 reset_n = 1'b0;
    #1;
    check("reset_color", 32'(bus.color), 32'h0);
    check("reset_hsync", 32'(bus.hsync), 32'h1);
    check("reset_vsync", 32'(bus.vsync), 32'h1);
    check("reset_done",  32'(bus.frame_done), 32'h0);
    check("reset_fcnt",  32'(bus.frame_count), 32'h0);
    check("reset_ovr",   32'(bus.overrun_count), 32'h0);
    tick();
    tick();
    #2 reset_n = 1'b1;
    tick();
    tick();

    // Table-driven pixel path: one cycle after applying, the old value must
    // still be visible; after the second, the new one.
    prev_exp = 8'h00;
    for (int i = 0; i < 11; i++) begin
      bus.mode         = vecs[i].mode;
      bus.x_pixel      = vecs[i].x;
      bus.y_pixel      = vecs[i].y;
      bus.layer_opaque = vecs[i].opq;
      bus.layer_color  = vecs[i].lc;
      bus.bg_color     = vecs[i].bg;
      tick();
      check($sformatf("vec%0d_lat1", i), 32'(bus.color), 32'(prev_exp));
      tick();
      check($sformatf("vec%0d_color", i), 32'(bus.color), 32'(vecs[i].exp));
      prev_exp = vecs[i].exp;
    end

    // Sync delay: pattern driven one bit per cycle, output lags by 2.
    hpat = 8'b1110_0011;   // bit n applied at step n: 1,1,0,0,0,1,1,1
    vpat = 8'b1100_1101;   // 1,0,1,1,0,0,1,1
    for (int n = 0; n < 10; n++) begin
      bus.hsync_in = (n < 8) ? hpat[n] : 1'b1;
      bus.vsync_in = (n < 8) ? vpat[n] : 1'b1;
      tick();
      check($sformatf("hsync_%0d", n), 32'(bus.hsync),
            32'((n == 0) ? 1'b1 : ((n - 1 < 8) ? hpat[n-1] : 1'b1)));
      check($sformatf("vsync_%0d", n), 32'(bus.vsync),
            32'((n == 0) ? 1'b1 : ((n - 1 < 8) ? vpat[n-1] : 1'b1)));
    end

    // Handshake
    bus.x_pixel = '0;
    bus.y_pixel = 10'd601;
    tick();
    bus.y_pixel = 10'd600;
    tick();
    check("hs_done_set", 32'(bus.frame_done), 32'h1);
    check("hs_fcnt1",    32'(bus.frame_count), 32'd1);
    tick();
    tick();
    tick();
    check("hs_stall_fcnt", 32'(bus.frame_count), 32'd1);
    bus.y_pixel   = 10'd601;
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    check("hs_ack_clear", 32'(bus.frame_done), 32'h0);
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    tick();
    check("hs_idle_ack_done", 32'(bus.frame_done), 32'h0);
    check("hs_idle_ack_fcnt", 32'(bus.frame_count), 32'd1);

    // Event and ack together while pending
    frame_evt();
    check("hs_pend2", 32'(bus.frame_done), 32'h1);
    bus.y_pixel   = 10'd600;
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    bus.y_pixel   = 10'd601;
    check("both_done", 32'(bus.frame_done), 32'h1);
    check("both_fcnt", 32'(bus.frame_count), 32'd3);
    tick();
    check("both_ovr", 32'(bus.overrun_count), 32'd0);
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    check("both_ack_clear", 32'(bus.frame_done), 32'h0);

    // Overruns
    for (int k = 0; k < 3; k++) frame_evt();
    check("ovr_fcnt", 32'(bus.frame_count), 32'd6);
    check("ovr_cnt2", 32'(bus.overrun_count), OVR_EN ? 32'd2 : 32'd0);
    check("ovr_done", 32'(bus.frame_done), 32'h1);
    for (int k = 0; k < 258; k++) frame_evt();
    check("ovr_sat", 32'(bus.overrun_count), OVR_EN ? 32'd255 : 32'd0);
    check("ovr_fcnt264", 32'(bus.frame_count), 32'd264);

    // Asynchronous reset mid-line with frame_done pending
    bus.x_pixel      = 11'd5;
    bus.y_pixel      = 10'd5;
    bus.mode         = 1'b0;
    bus.layer_opaque = 3'b001;
    bus.layer_color  = 24'h0000AA;
    bus.hsync_in     = 1'b0;
    bus.vsync_in     = 1'b0;
    tick();
    tick();
    check("pre_rst_color", 32'(bus.color), 32'hAA);
    #2 reset_n = 1'b0;
    #1;
    check("arst_color", 32'(bus.color), 32'h0);
    check("arst_hsync", 32'(bus.hsync), 32'h1);
    check("arst_vsync", 32'(bus.vsync), 32'h1);
    check("arst_done",  32'(bus.frame_done), 32'h0);
    check("arst_fcnt",  32'(bus.frame_count), 32'h0);
    check("arst_ovr",   32'(bus.overrun_count), 32'h0);
    bus.layer_color = 24'h000033;
    bus.hsync_in    = 1'b1;
    bus.vsync_in    = 1'b1;
    #3 reset_n = 1'b1;
    tick();
    check("post_rst_lat1", 32'(bus.color), 32'h0);
    tick();
    check("post_rst_color", 32'(bus.color), 32'h33);
    bus.x_pixel = '0;
    frame_evt();
    check("post_rst_fcnt", 32'(bus.frame_count), 32'd1);
    check("post_rst_done", 32'(bus.frame_done), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
